// File: rtl/irrigation_pkg.sv
// ============================================================================
// Module      : irrigation_pkg
// Description : Shared encodings, FSM states and default constants for the
//               valve/sensor irrigation plant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irrigation_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_HIGH_ON  = 2'b01;
    localparam logic [1:0] FAULT_MID_OFF  = 2'b10;
    localparam logic [1:0] FAULT_LOW_OFF  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } tank_state_e;

    localparam int c_DEF_TICK_DIV    = 50000;
    localparam int c_DEF_LEVEL_MAX   = 200;
    localparam int c_DEF_INIT_LEVEL  = 0;
    localparam int c_DEF_FILL_RATE   = 4;
    localparam int c_DEF_SPRINK_RATE = 3;
    localparam int c_DEF_DRIP_RATE   = 1;
    localparam int c_DEF_LOW_TH      = 40;
    localparam int c_DEF_MID_TH      = 100;
    localparam int c_DEF_HIGH_TH     = 160;
    localparam int c_DEF_HYST        = 4;

    function automatic tank_state_e state_of_level(input logic [7:0] lvl,
                                                   input logic [7:0] lvl_max);
        if (lvl == 8'd0)
            return ST_EMPTY;
        else if (lvl == lvl_max)
            return ST_FULL;
        else
            return ST_NORMAL;
    endfunction

    // Set at/above the threshold, clear only once below the hysteresis band.
    function automatic logic sensor_next(input logic       cur,
                                         input logic [7:0] lvl,
                                         input logic [7:0] set_th,
                                         input logic [7:0] clr_th);
        if (lvl >= set_th)
            return 1'b1;
        else if (lvl < clr_th)
            return 1'b0;
        else
            return cur;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler producing a one-cycle strobe every DIV
//               clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_count_q;
    logic [c_CW-1:0] w_count_d;

    always_comb begin
        w_count_d = (r_count_q == c_LAST) ? '0 : r_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_count_q <= '0;
        else
            r_count_q <= w_count_d;
    end

    // Gated by reset so a reset landing on the last count swallows the strobe.
    assign tick = ~reset & (r_count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/tank_plant_model.sv
// ============================================================================
// Module      : tank_plant_model
// Description : Tank plant: integrates valve flows per tick into a saturated
//               level, drives hysteretic level sensors and sticky fault flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_plant_model
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV    = c_DEF_TICK_DIV,
    parameter int LEVEL_MAX   = c_DEF_LEVEL_MAX,
    parameter int INIT_LEVEL  = c_DEF_INIT_LEVEL,
    parameter int FILL_RATE   = c_DEF_FILL_RATE,
    parameter int SPRINK_RATE = c_DEF_SPRINK_RATE,
    parameter int DRIP_RATE   = c_DEF_DRIP_RATE,
    parameter int LOW_TH      = c_DEF_LOW_TH,
    parameter int MID_TH      = c_DEF_MID_TH,
    parameter int HIGH_TH     = c_DEF_HIGH_TH,
    parameter int HYST        = c_DEF_HYST
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valvulaDeEntrada,
    input  logic       valvulaDeAspersao,
    input  logic       valvulaDeGotejamento,
    input  logic [1:0] fault_sel,
    input  logic       clear_flags,
    output logic       high,
    output logic       middle,
    output logic       low,
    output logic [7:0] level,
    output logic       overflow,
    output logic       dry_run,
    output logic       tick
);

    localparam logic signed [9:0] c_FILL   = 10'(FILL_RATE);
    localparam logic signed [9:0] c_SPRINK = 10'(SPRINK_RATE);
    localparam logic signed [9:0] c_DRIP   = 10'(DRIP_RATE);
    localparam logic signed [9:0] c_MAX_S  = 10'(LEVEL_MAX);

    localparam logic [7:0] c_LEVEL_MAX = 8'(LEVEL_MAX);
    localparam logic [7:0] c_INIT      = 8'(INIT_LEVEL);
    localparam logic [7:0] c_LOW_SET   = 8'(LOW_TH);
    localparam logic [7:0] c_LOW_CLR   = 8'(LOW_TH - HYST);
    localparam logic [7:0] c_MID_SET   = 8'(MID_TH);
    localparam logic [7:0] c_MID_CLR   = 8'(MID_TH - HYST);
    localparam logic [7:0] c_HIGH_SET  = 8'(HIGH_TH);
    localparam logic [7:0] c_HIGH_CLR  = 8'(HIGH_TH - HYST);

    logic              w_tick;
    logic        [7:0] r_level_q, w_level_d;
    logic signed [9:0] w_sum;
    tank_state_e       r_state_q, w_state_d;
    logic              r_ovf_q, w_ovf_d, w_ovf_set;
    logic              r_dry_q, w_dry_d, w_dry_set;
    logic              r_high_q, r_mid_q, r_low_q;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_comb begin
        w_sum = $signed({2'b00, r_level_q});
        if (valvulaDeEntrada)     w_sum = w_sum + c_FILL;
        if (valvulaDeAspersao)    w_sum = w_sum - c_SPRINK;
        if (valvulaDeGotejamento) w_sum = w_sum - c_DRIP;

        w_level_d = r_level_q;
        if (w_tick) begin
            if (w_sum < 10'sd0)
                w_level_d = 8'd0;
            else if (w_sum > c_MAX_S)
                w_level_d = c_LEVEL_MAX;
            else
                w_level_d = w_sum[7:0];
        end
    end

    // State only moves on tick, so FULL/EMPTY always mirror the held level.
    always_comb begin
        w_state_d = r_state_q;
        if (w_tick)
            w_state_d = state_of_level(w_level_d, c_LEVEL_MAX);
    end

    always_comb begin
        w_ovf_set = w_tick & (r_state_q == ST_FULL) & valvulaDeEntrada;
        w_dry_set = w_tick & (r_state_q == ST_EMPTY)
                  & (valvulaDeAspersao | valvulaDeGotejamento);
        w_ovf_d   = w_ovf_set | (r_ovf_q & ~clear_flags);
        w_dry_d   = w_dry_set | (r_dry_q & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_q <= c_INIT;
            r_state_q <= state_of_level(c_INIT, c_LEVEL_MAX);
            r_ovf_q   <= 1'b0;
            r_dry_q   <= 1'b0;
            r_high_q  <= 1'b0;
            r_mid_q   <= 1'b0;
            r_low_q   <= 1'b0;
        end else begin
            r_level_q <= w_level_d;
            r_state_q <= w_state_d;
            r_ovf_q   <= w_ovf_d;
            r_dry_q   <= w_dry_d;
            r_high_q  <= sensor_next(r_high_q, r_level_q, c_HIGH_SET, c_HIGH_CLR);
            r_mid_q   <= sensor_next(r_mid_q,  r_level_q, c_MID_SET,  c_MID_CLR);
            r_low_q   <= sensor_next(r_low_q,  r_level_q, c_LOW_SET,  c_LOW_CLR);
        end
    end

    assign high     = r_high_q | (fault_sel == FAULT_HIGH_ON);
    assign middle   = r_mid_q  & (fault_sel != FAULT_MID_OFF);
    assign low      = r_low_q  & (fault_sel != FAULT_LOW_OFF);
    assign level    = r_level_q;
    assign overflow = r_ovf_q;
    assign dry_run  = r_dry_q;
    assign tick     = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_tank_plant_model.sv
// ============================================================================
// Module      : tb_tank_plant_model
// Description : Scoreboard bench for tank_plant_model with a tick-level
//               arithmetic reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tank_plant_model;
    import irrigation_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int LEVEL_MAX  = 200;
    localparam int INIT_LEVEL = 0;
    localparam int FILL       = 4;
    localparam int SPRINK     = 3;
    localparam int DRIP       = 1;
    localparam int LOW_TH     = 40;
    localparam int MID_TH     = 100;
    localparam int HIGH_TH    = 160;
    localparam int HYST       = 4;

    typedef struct packed {
        logic [7:0] level;
        logic [1:0] st;
        logic       tick;
        logic       hi;
        logic       mi;
        logic       lo;
        logic       ovf;
        logic       dry;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v_in = 1'b0, v_sp = 1'b0, v_dr = 1'b0;
    logic [1:0] fsel = 2'b00;
    logic       clr = 1'b0;
    logic       high, middle, low, overflow, dry_run, tick;
    logic [7:0] level;

    obs_t q_exp[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state, held at the reset values.
    int m_level = INIT_LEVEL;
    int m_cnt   = 0;
    bit m_ovf = 0, m_dry = 0, m_hi = 0, m_mi = 0, m_lo = 0;

    tank_plant_model #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .valvulaDeEntrada     (v_in),
        .valvulaDeAspersao    (v_sp),
        .valvulaDeGotejamento (v_dr),
        .fault_sel            (fsel),
        .clear_flags          (clr),
        .high                 (high),
        .middle               (middle),
        .low                  (low),
        .level                (level),
        .overflow             (overflow),
        .dry_run              (dry_run),
        .tick                 (tick)
    );

    always #5 clk = ~clk;

    function automatic bit hyst_next(bit cur, int lvl, int th);
        if (lvl >= th)        return 1'b1;
        if (lvl < th - HYST)  return 1'b0;
        return cur;
    endfunction

    // One clock: drive inputs, log what the DUT must show now, then advance
    // the model across the coming edge.
    task automatic step(input bit r, input bit vi, input bit vs, input bit vd,
                        input bit [1:0] fs, input bit cl);
        obs_t e;
        bit   tk;
        int   nxt;
        @(negedge clk);
        reset = r; v_in = vi; v_sp = vs; v_dr = vd; fsel = fs; clr = cl;

        tk      = !r && (m_cnt == TICK_DIV - 1);
        e.level = 8'(m_level);
        e.st    = (m_level == 0) ? ST_EMPTY :
                  (m_level == LEVEL_MAX) ? ST_FULL : ST_NORMAL;
        e.tick  = tk;
        e.hi    = m_hi || (fs == 2'b01);
        e.mi    = m_mi && (fs != 2'b10);
        e.lo    = m_lo && (fs != 2'b11);
        e.ovf   = m_ovf;
        e.dry   = m_dry;
        q_exp.push_back(e);

        if (r) begin
            m_level = INIT_LEVEL; m_cnt = 0;
            m_ovf = 0; m_dry = 0; m_hi = 0; m_mi = 0; m_lo = 0;
        end else begin
            m_hi  = hyst_next(m_hi, m_level, HIGH_TH);
            m_mi  = hyst_next(m_mi, m_level, MID_TH);
            m_lo  = hyst_next(m_lo, m_level, LOW_TH);
            m_ovf = (tk && m_level == LEVEL_MAX && vi) || (m_ovf && !cl);
            m_dry = (tk && m_level == 0 && (vs || vd)) || (m_dry && !cl);
            if (tk) begin
                nxt = m_level + FILL * int'(vi) - SPRINK * int'(vs) - DRIP * int'(vd);
                if (nxt < 0) nxt = 0;
                if (nxt > LEVEL_MAX) nxt = LEVEL_MAX;
                m_level = nxt;
            end
            m_cnt = (m_cnt + 1) % TICK_DIV;
        end
    endtask

    task automatic goto_level(input int target);
        int guard = 0;
        while (m_level != target && guard < 3000) begin
            if (m_level < target)
                step(0, 1, 0, 0, 2'b00, 0);
            else if (m_level - target >= SPRINK)
                step(0, 0, 1, 0, 2'b00, 0);
            else
                step(0, 0, 0, 1, 2'b00, 0);
            guard++;
        end
        if (m_level != target) begin
            checks++;
            $display("FAIL goto_level: model level %0d, target %0d", m_level, target);
        end
    endtask

    // Monitor: each cycle the DUT presents its outputs, pop and compare.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            #2;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                a.level = level;
                a.st    = dut.r_state_q;
                a.tick  = tick;
                a.hi    = high;
                a.mi    = middle;
                a.lo    = low;
                a.ovf   = overflow;
                a.dry   = dry_run;
                checks++;
                if (a !== e)
                    $display("FAIL outputs @%0t: got lvl=%0d st=%0d tick=%b h/m/l=%b%b%b ovf=%b dry=%b, want lvl=%0d st=%0d tick=%b h/m/l=%b%b%b ovf=%b dry=%b",
                             $time, a.level, a.st, a.tick, a.hi, a.mi, a.lo, a.ovf, a.dry,
                             e.level, e.st, e.tick, e.hi, e.mi, e.lo, e.ovf, e.dry);
                else
                    passes++;
            end
        end
    end

    initial begin
        int wait_cnt;
        repeat (3) step(1, 0, 0, 0, 2'b00, 0);

        // Ten inlet ticks from empty, then let the low sensor settle.
        repeat (10 * TICK_DIV) step(0, 1, 0, 0, 2'b00, 0);
        repeat (3) step(0, 0, 0, 0, 2'b00, 0);

        // Drip down through the low sensor hysteresis band.
        wait_cnt = 0;
        while (m_level > 35 && wait_cnt < 200) begin
            step(0, 0, 0, 1, 2'b00, 0);
            wait_cnt++;
        end
        repeat (3) step(0, 0, 0, 0, 2'b00, 0);

        // Saturate at full, provoke overflow, then clear it.
        goto_level(198);
        repeat (4 * TICK_DIV) step(0, 1, 0, 0, 2'b00, 0);
        repeat (3) step(0, 0, 0, 0, 2'b00, 1);
        repeat (2) step(0, 0, 0, 0, 2'b00, 0);

        // Drain to empty, provoke dry run, clear on the very tick that sets it.
        goto_level(2);
        repeat (3 * TICK_DIV) step(0, 0, 1, 0, 2'b00, 0);
        wait_cnt = 0;
        while (m_cnt != TICK_DIV - 1 && wait_cnt < 10) begin
            step(0, 0, 1, 0, 2'b00, 0);
            wait_cnt++;
        end
        step(0, 0, 1, 0, 2'b00, 1);
        repeat (2) step(0, 0, 0, 0, 2'b00, 0);

        // Sensor fault overrides at a mid-high level.
        goto_level(120);
        repeat (2) step(0, 0, 0, 0, 2'b00, 0);
        for (int f = 0; f < 4; f++)
            repeat (3) step(0, 0, 0, 0, 2'(f), 0);

        // All valves together leave the level alone.
        repeat (2 * TICK_DIV) step(0, 1, 1, 1, 2'b00, 0);

        // Reset landing on the last prescaler count.
        goto_level(50);
        wait_cnt = 0;
        while (m_cnt != TICK_DIV - 1 && wait_cnt < 10) begin
            step(0, 1, 0, 0, 2'b00, 0);
            wait_cnt++;
        end
        repeat (2) step(1, 1, 0, 0, 2'b00, 0);
        repeat (3 * TICK_DIV) step(0, 1, 0, 0, 2'b00, 0);

        // Randomised phases alternately biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 150; i++) begin
                bit vi, vs, vd, cl, rr;
                bit [1:0] fs;
                vi = (ph % 2 == 0) ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 2);
                vs = (ph % 2 == 0) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8);
                vd = $urandom_range(1, 0) == 1;
                cl = $urandom_range(19, 0) == 0;
                rr = $urandom_range(299, 0) == 0;
                fs = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
                step(rr, vi, vs, vd, fs, cl);
            end
        end

        step(0, 0, 0, 0, 2'b00, 0);
        wait_cnt = 0;
        while (q_exp.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #5;
        if (q_exp.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
